run_controller: RTL and testbench

Session sequencer that sits directly upstream of the processor core. While the core is idle it owns the data-memory port, streams a byte image into data memory, and launches the core with a one-cycle start pulse. It then times the run until the core reports completion (or a timeout fires) and streams a window of data memory back out, so a bench or host can drive complete load/run/readback sessions through one block.

---
 rtl/run_controller_if.sv | 62 ++++++
 rtl/run_controller.sv | 163 ++++++++++++++++
 tb/tb_run_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// Bus bundle for run_controller: session parameters, load stream,
// data-memory port, core handshake, readback stream and status.
interface run_controller_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned CNT_BITS  = 16
);
    logic                 go;
    logic [ADDR_BITS-1:0] load_base;
    logic [7:0]           load_len;
    logic [ADDR_BITS-1:0] dump_base;
    logic [7:0]           dump_len;

    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;

    logic                 mem_own;
    logic                 dm_we;
    logic [ADDR_BITS-1:0] dm_addr;
    logic [7:0]           dm_wdata;
    logic [7:0]           dm_rdata;

    logic                 core_start;
    logic                 core_done;

    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;

    logic                 busy;
    logic                 finished;
    logic                 timed_out;
    logic [CNT_BITS-1:0]  cycles;

    // Controller side
    modport master (
        input  go, load_base, load_len, dump_base, dump_len,
        input  in_valid, in_data,
        output in_ready,
        output mem_own, dm_we, dm_addr, dm_wdata,
        input  dm_rdata,
        output core_start,
        input  core_done,
        output out_valid, out_data,
        input  out_ready,
        output busy, finished, timed_out, cycles
    );

    // Host / memory / core side
    modport slave (
        output go, load_base, load_len, dump_base, dump_len,
        output in_valid, in_data,
        input  in_ready,
        input  mem_own, dm_we, dm_addr, dm_wdata,
        output dm_rdata,
        input  core_start,
        output core_done,
        input  out_valid, out_data,
        output out_ready,
        input  busy, finished, timed_out, cycles
    );
endinterface

// File: rtl/run_controller.sv
// Session sequencer: loads a byte image into data memory, kicks the core,
// times the run (with timeout) and streams a window of memory back out.
module run_controller #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned CNT_BITS  = 16,
    parameter int unsigned TIMEOUT   = 4095
) (
    input logic clock,
    input logic start,
    run_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_RUN,
        S_DUMP,
        S_FIN
    } state_t;

    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] load_base_q, load_base_d;
    logic [7:0]           load_len_q, load_len_d;
    logic [ADDR_BITS-1:0] dump_base_q, dump_base_d;
    logic [7:0]           dump_len_q, dump_len_d;
    logic [7:0]           idx_q, idx_d;
    logic                 timed_out_q, timed_out_d;
    logic [CNT_BITS-1:0]  cycles_q, cycles_d;
    logic [CNT_BITS-1:0]  cycles_inc;

    assign cycles_inc = cycles_q + 1'b1;

    // State and session registers; start clears everything asynchronously
    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            state_q     <= S_IDLE;
            load_base_q <= '0;
            load_len_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
            idx_q       <= '0;
            timed_out_q <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_base_q <= load_base_d;
            load_len_q  <= load_len_d;
            dump_base_q <= dump_base_d;
            dump_len_q  <= dump_len_d;
            idx_q       <= idx_d;
            timed_out_q <= timed_out_d;
            cycles_q    <= cycles_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        load_base_d = load_base_q;
        load_len_d  = load_len_q;
        dump_base_d = dump_base_q;
        dump_len_d  = dump_len_q;
        idx_d       = idx_q;
        timed_out_d = timed_out_q;
        cycles_d    = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    load_base_d = bus.load_base;
                    load_len_d  = bus.load_len;
                    dump_base_d = bus.dump_base;
                    dump_len_d  = bus.dump_len;
                    idx_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = (bus.load_len != 8'd0) ? S_LOAD : S_KICK;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (idx_q == load_len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_KICK;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_KICK: begin
                cycles_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                // The exit edge still counts, so a done seen on the first
                // RUN edge reports one cycle.
                cycles_d = cycles_inc;
                if (bus.core_done) begin
                    state_d = (dump_len_q != 8'd0) ? S_DUMP : S_FIN;
                end else if (cycles_inc == TIMEOUT_C) begin
                    timed_out_d = 1'b1;
                    state_d     = S_FIN;
                end
            end
            S_DUMP: begin
                if (bus.out_ready) begin
                    if (idx_q == dump_len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and registers; dm_we qualifies in_valid
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.mem_own    = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.core_start = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.busy       = (state_q != S_IDLE);
        bus.finished   = (state_q == S_FIN);
        bus.timed_out  = timed_out_q;
        bus.cycles     = cycles_q;

        case (state_q)
            S_LOAD: begin
                bus.mem_own  = 1'b1;
                bus.in_ready = 1'b1;
                bus.dm_addr  = load_base_q + ADDR_BITS'(idx_q);
                bus.dm_wdata = bus.in_data;
                bus.dm_we    = bus.in_valid;
            end
            S_KICK: begin
                bus.core_start = 1'b1;
            end
            S_DUMP: begin
                bus.mem_own   = 1'b1;
                bus.dm_addr   = dump_base_q + ADDR_BITS'(idx_q);
                bus.out_valid = 1'b1;
                bus.out_data  = bus.dm_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: memory model, write and readback
// scoreboards, and session sequences covering load, run, timeout and dump.
module tb_run_controller;

    logic clock;
    logic start;

    int checks    = 0;
    int errors    = 0;
    int own_count = 0;
    int cs_count  = 0;
    int fin_count = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] oq[$];
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    run_controller_if #(.ADDR_BITS(8), .CNT_BITS(16)) bus ();

    run_controller #(.ADDR_BITS(8), .CNT_BITS(16), .TIMEOUT(50)) dut (
        .clock (clock),
        .start (start),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: combinational read, write on the rising edge
    assign bus.dm_rdata = mem[bus.dm_addr];
    always @(posedge clock) begin
        if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled just after the falling edge
    always @(negedge clock) begin
        #1;
        if (bus.mem_own === 1'b1) own_count++;
        if (bus.core_start === 1'b1) cs_count++;
        if (bus.finished === 1'b1) fin_count++;
        if (bus.dm_we === 1'b1) begin
            check("wr_pending", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                check("wr_addr", 32'(bus.dm_addr), 32'(wq[0].a));
                check("wr_data", 32'(bus.dm_wdata), 32'(wq[0].d));
                void'(wq.pop_front());
            end
        end
        if (bus.out_valid === 1'b1) begin
            check("rd_pending", 32'(oq.size() > 0), 32'd1);
            if (oq.size() > 0) begin
                check("rd_data", 32'(bus.out_data), 32'(oq[0]));
                if (bus.out_ready === 1'b1) void'(oq.pop_front());
            end
        end
    end

    task automatic session(input logic [7:0] lb, input logic [7:0] ll,
                           input logic [7:0] db, input logic [7:0] dl,
                           input logic [7:0] seed, input bit in_gap,
                           input bit out_tog, input int done_after,
                           input bit stale, input bit exp_to,
                           input logic [15:0] exp_cycles);
        int fs0, cs0, own0;
        logic [7:0] d;
        logic [7:0] a;
        bit got_fin;
        fs0  = fin_count;
        cs0  = cs_count;
        own0 = own_count;
        got_fin = 1'b0;
        bus.out_ready = 1'b1;
        bus.core_done = stale;
        bus.load_base = lb;
        bus.load_len  = ll;
        bus.dump_base = db;
        bus.dump_len  = dl;
        bus.go = 1'b1;
        @(negedge clock);
        bus.go = 1'b0;
        for (int i = 0; i < int'(ll); i++) begin
            d = seed + 8'(8'h11 * i);
            a = lb + 8'(i);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            wq.push_back('{a: a, d: d});
            exp_mem[a] = d;
            @(negedge clock);
            if (in_gap && i != int'(ll) - 1) begin
                bus.in_valid = 1'b0;
                @(negedge clock);
            end
        end
        bus.in_valid = 1'b0;
        #2;
        check("kick_start", 32'(bus.core_start), 32'd1);
        if (!exp_to) begin
            for (int j = 0; j < int'(dl); j++) oq.push_back(exp_mem[8'(db + 8'(j))]);
        end
        // go pulsed while busy must be ignored
        @(negedge clock);
        bus.go = 1'b1;
        bus.load_len = 8'd7;
        @(negedge clock);
        bus.go = 1'b0;
        if (stale) bus.core_done = 1'b0;
        if (done_after >= 2) begin
            repeat (done_after - 2) @(negedge clock);
            bus.core_done = 1'b1;
            @(negedge clock);
            bus.core_done = 1'b0;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            bus.out_ready = out_tog ? ~bus.out_ready : 1'b1;
            #2;
            if (fin_count != fs0) begin
                got_fin = 1'b1;
                break;
            end
        end
        check("fin_within_budget", 32'(got_fin), 32'd1);
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clock);
        #2;
        check("fin_pulses", 32'(fin_count - fs0), 32'd1);
        check("start_pulses", 32'(cs_count - cs0), 32'd1);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("timed_out", 32'(bus.timed_out), 32'(exp_to));
        check("cycles", 32'(bus.cycles), 32'(exp_cycles));
        check("rd_left", 32'(oq.size()), 32'd0);
        check("wr_left", 32'(wq.size()), 32'd0);
        if (ll == 8'd0 && dl == 8'd0) check("no_own", 32'(own_count - own0), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        start         = 1'b1;
        bus.go        = 1'b0;
        bus.load_base = '0;
        bus.load_len  = '0;
        bus.dump_base = '0;
        bus.dump_len  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.core_done = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clock);
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_own", 32'(bus.mem_own), 32'd0);
        check("rst_dm_we", 32'(bus.dm_we), 32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_finished", 32'(bus.finished), 32'd0);
        check("rst_timed_out", 32'(bus.timed_out), 32'd0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        check("rst_dm_wdata", 32'(bus.dm_wdata), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_cycles", 32'(bus.cycles), 32'd0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);

        // Full session
        session(8'h10, 8'd3, 8'h10, 8'd3, 8'hA1, 1'b0, 1'b0, 20, 1'b0, 1'b0, 16'd20);

        // Asynchronous reset mid-LOAD after two bytes
        bus.load_base = 8'h40;
        bus.load_len  = 8'd5;
        bus.dump_len  = 8'd0;
        bus.go = 1'b1;
        @(negedge clock);
        bus.go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h60 + 8'(i);
            wq.push_back('{a: 8'h40 + 8'(i), d: 8'h60 + 8'(i)});
            exp_mem[8'h40 + 8'(i)] = 8'h60 + 8'(i);
            @(negedge clock);
        end
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        #2;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_dm_we", 32'(bus.dm_we), 32'd0);
        check("arst_mem_own", 32'(bus.mem_own), 32'd0);
        check("arst_cycles", 32'(bus.cycles), 32'd0);
        check("arst_wr_left", 32'(wq.size()), 32'd0);
        #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);

        // Backpressure on both streams; also confirms a clean restart
        session(8'h80, 8'd5, 8'h80, 8'd5, 8'h31, 1'b1, 1'b1, 10, 1'b0, 1'b0, 16'd10);

        // Timeout: done never raised
        session(8'h20, 8'd2, 8'h20, 8'd2, 8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'd50);

        // Zero lengths
        session(8'h00, 8'd0, 8'h00, 8'd0, 8'h00, 1'b0, 1'b0, 10, 1'b0, 1'b0, 16'd10);

        // Address wrap
        session(8'hFE, 8'd4, 8'hFE, 8'd4, 8'h5A, 1'b0, 1'b0, 10, 1'b0, 1'b0, 16'd10);

        // Stale done held from before go
        session(8'h00, 8'd0, 8'h00, 8'd0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 16'd1);

        // Readback of earlier loaded window without a new load
        session(8'h00, 8'd0, 8'h10, 8'd3, 8'h00, 1'b0, 1'b1, 10, 1'b0, 1'b0, 16'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
